// File: rtl/stage_if_if.sv
// Instruction-memory request/acknowledge port between the IF stage and memory.
interface stage_if_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/stage_if.sv
// IF stage: owns the PC, fetches over a req/ack memory port with wait states,
// feeds the IF/ID register, honours one branch delay slot, never squashes.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic [31:0]       pc_b,
    input  logic [31:0]       pc_j,
    input  logic [31:0]       pc_r,
    input  logic [1:0]        pc_select,
    input  logic              stall,
    stage_if_if.master        imem,
    output logic [31:0]       pc4_id,
    output logic [31:0]       instr_id,
    output logic              valid_id
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] skid_instr_q, skid_pc4_q;
    logic        pend_q;
    logic [31:0] pend_tgt_q;
    logic [31:0] pc4_id_q, instr_id_q;
    logic        valid_id_q;

    logic [31:0] tgt, seq_pc, npc;
    logic        redir;

    // Request comes straight from registered state, so memory inputs never loop back.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign pc4_id         = pc4_id_q;
    assign instr_id       = instr_id_q;
    assign valid_id       = valid_id_q;

    // Redirect target chosen by ID; only meaningful when redir is set.
    always_comb begin
        tgt = pc_b;
        case (pc_select)
            2'b10:   tgt = pc_r;
            2'b11:   tgt = pc_j;
            default: tgt = pc_b;
        endcase
    end

    // A redirect only counts for a real, non-stalled instruction in ID.
    assign redir  = valid_id_q & ~stall & (pc_select != 2'b00);
    assign seq_pc = pc_q + 32'd4;
    assign npc    = redir ? tgt : (pend_q ? pend_tgt_q : seq_pc);

    // Fetch FSM together with PC, skid buffer, pending redirect and IF/ID register.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            pc4_id_q     <= '0;
            instr_id_q   <= '0;
            valid_id_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_q   <= npc;
                        pend_q <= 1'b0;
                        if (stall) begin
                            // ID is frozen: park the word until the stall clears.
                            skid_instr_q <= imem.imem_data;
                            skid_pc4_q   <= seq_pc;
                            state_q      <= HOLD;
                        end else begin
                            pc4_id_q   <= seq_pc;
                            instr_id_q <= imem.imem_data;
                            valid_id_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        pc4_id_q   <= '0;
                        instr_id_q <= '0;
                        valid_id_q <= 1'b0;
                        // In-flight word is the delay slot; remember where to go after it.
                        if (redir) begin
                            pend_q     <= 1'b1;
                            pend_tgt_q <= tgt;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc4_id_q   <= skid_pc4_q;
                        instr_id_q <= skid_instr_q;
                        valid_id_q <= 1'b1;
                        // Buffered word is the delay slot, so the target is fetched next.
                        if (redir) pc_q <= tgt;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: reset, sequential fetch, branches, waits, stalls, async reset.
module tb_stage_if;
    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic [31:0] pc_b = '0, pc_j = '0, pc_r = '0;
    logic [1:0]  pc_select = '0;
    logic        stall = 1'b0;
    logic        ack = 1'b1;
    logic [31:0] pc4_id, instr_id;
    logic        valid_id;
    int          passed = 0, total = 0;
    logic [97:0] o, e;

    stage_if_if bus();

    stage_if #(.RESET_PC(32'h0000_0040)) dut (
        .clock(clock), .reset_0(reset_0),
        .pc_b(pc_b), .pc_j(pc_j), .pc_r(pc_r), .pc_select(pc_select),
        .stall(stall), .imem(bus),
        .pc4_id(pc4_id), .instr_id(instr_id), .valid_id(valid_id)
    );

    always #5 clock = ~clock;

    // Memory image: word content is derived from its address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ack  = ack;
    assign bus.imem_data = w(bus.imem_addr);

    function automatic logic [97:0] obs();
        return {bus.imem_req, bus.imem_addr, pc4_id, instr_id, valid_id};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset, then redirect so that ID holds word @t and the fetch address is t+4.
    task automatic goto(input logic [31:0] t);
        reset_0 = 1'b0; ack = 1'b1; stall = 1'b0; pc_select = 2'b00;
        step();
        reset_0 = 1'b1;
        step();
        step();
        pc_select = 2'b11; pc_j = t;
        step();
        pc_select = 2'b00;
        step();
    endtask

    task automatic test_reset();
        reset_0 = 1'b0; ack = 1'b1; stall = 1'b0; pc_select = 2'b00;
        step(); step();
        e = {1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
        o = obs(); total++; if (o !== e) $display("FAIL reset_state got %h want %h", o, e); else passed++;
        reset_0 = 1'b1;
        step();
        e = {1'b1, 32'h40, 32'h0, 32'h0, 1'b0};
        o = obs(); total++; if (o !== e) $display("FAIL first_req got %h want %h", o, e); else passed++;
        for (int k = 0; k < 4; k++) begin
            step();
            e = {1'b1, 32'h44 + 32'(4*k), 32'h44 + 32'(4*k), w(32'h40 + 32'(4*k)), 1'b1};
            o = obs(); total++; if (o !== e) $display("FAIL seq_fetch%0d got %h want %h", k, o, e); else passed++;
        end
    endtask

    task automatic test_branch();
        goto(32'h100);
        e = {1'b1, 32'h104, 32'h104, w(32'h100), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL br_setup got %h want %h", o, e); else passed++;
        pc_select = 2'b01; pc_b = 32'h200;
        step();
        pc_select = 2'b00;
        e = {1'b1, 32'h200, 32'h108, w(32'h104), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL br_delay_slot got %h want %h", o, e); else passed++;
        step();
        e = {1'b1, 32'h204, 32'h204, w(32'h200), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL br_target got %h want %h", o, e); else passed++;
    endtask

    task automatic test_wait_redirect();
        goto(32'h100);
        ack = 1'b0; pc_select = 2'b10; pc_r = 32'h300;
        step();
        pc_select = 2'b00;
        e = {1'b1, 32'h104, 32'h0, 32'h0, 1'b0};
        o = obs(); total++; if (o !== e) $display("FAIL wait_bubble0 got %h want %h", o, e); else passed++;
        total++; if (dut.pend_q !== 1'b1) $display("FAIL wait_pend got %b want 1", dut.pend_q); else passed++;
        for (int k = 1; k < 3; k++) begin
            step();
            o = obs(); total++; if (o !== e) $display("FAIL wait_bubble%0d got %h want %h", k, o, e); else passed++;
        end
        ack = 1'b1;
        step();
        e = {1'b1, 32'h300, 32'h108, w(32'h104), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL wait_slot got %h want %h", o, e); else passed++;
        total++; if (dut.pend_q !== 1'b0) $display("FAIL wait_pend_clr got %b want 0", dut.pend_q); else passed++;
        step();
        e = {1'b1, 32'h304, 32'h304, w(32'h300), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL wait_target got %h want %h", o, e); else passed++;
    endtask

    task automatic test_stall_ack();
        goto(32'h100);
        step();
        stall = 1'b1;
        step();
        e = {1'b0, 32'h10C, 32'h108, w(32'h104), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL stall_hold0 got %h want %h", o, e); else passed++;
        step();
        o = obs(); total++; if (o !== e) $display("FAIL stall_hold1 got %h want %h", o, e); else passed++;
        stall = 1'b0;
        step();
        e = {1'b1, 32'h10C, 32'h10C, w(32'h108), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL stall_skid got %h want %h", o, e); else passed++;
        step();
        e = {1'b1, 32'h110, 32'h110, w(32'h10C), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL stall_resume got %h want %h", o, e); else passed++;
    endtask

    task automatic test_hold_redirect();
        goto(32'h0FF8);
        stall = 1'b1;
        step();
        e = {1'b0, 32'h1000, 32'h0FFC, w(32'h0FF8), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL hold_enter got %h want %h", o, e); else passed++;
        stall = 1'b0; pc_select = 2'b11; pc_j = 32'h0;
        step();
        pc_select = 2'b00;
        e = {1'b1, 32'h0, 32'h1000, w(32'h0FFC), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL hold_redir got %h want %h", o, e); else passed++;
        step();
        e = {1'b1, 32'h4, 32'h4, w(32'h0), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL hold_target got %h want %h", o, e); else passed++;
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFFC);
        e = {1'b1, 32'h0, 32'h0, w(32'hFFFF_FFFC), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL wrap_pc4 got %h want %h", o, e); else passed++;
        step();
        e = {1'b1, 32'h4, 32'h4, w(32'h0), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL wrap_next got %h want %h", o, e); else passed++;
    endtask

    task automatic test_async_reset();
        goto(32'h100);
        ack = 1'b0;
        step();
        #2;
        reset_0 = 1'b0;
        #1;
        e = {1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
        o = obs(); total++; if (o !== e) $display("FAIL areset_imm got %h want %h", o, e); else passed++;
        ack = 1'b1;
        step();
        o = obs(); total++; if (o !== e) $display("FAIL areset_late_ack got %h want %h", o, e); else passed++;
        reset_0 = 1'b1;
        step();
        e = {1'b1, 32'h40, 32'h0, 32'h0, 1'b0};
        o = obs(); total++; if (o !== e) $display("FAIL areset_refetch got %h want %h", o, e); else passed++;
        step();
        e = {1'b1, 32'h44, 32'h44, w(32'h40), 1'b1};
        o = obs(); total++; if (o !== e) $display("FAIL areset_first got %h want %h", o, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wait_redirect();
        test_stall_ack();
        test_hold_redirect();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stage_if.md
# stage_if

Stage 1 (IF) of the 5-stage MIPS pipeline. It owns the program counter and fetches words over a request/acknowledge instruction-memory port that may insert wait states. It delivers each fetched instruction and its PC+4 through the IF/ID pipeline register to stage ID. From ID it takes `stall` and the redirect selector/targets, and honours one branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

- `clock`, in, 1: rising-edge clock.
- `reset_0`, in, 1: asynchronous, active-low reset.
- `pc_b`, in, 32: branch target from ID.
- `pc_j`, in, 32: jump target (j/jal) from ID.
- `pc_r`, in, 32: register target (jr, forwarded rs value) from ID.
- `pc_select`, in, 2: redirect code; 00 sequential, 01 `pc_b`, 10 `pc_r`, 11 `pc_j`.
- `stall`, in, 1: ID load-use stall; freeze the IF/ID register.
- `imem_req`, out, 1: fetch request, level.
- `imem_addr`, out, 32: fetch address; equals `pc`.
- `imem_ack`, in, 1: transfer completes on a rising edge where `imem_req & imem_ack`.
- `imem_data`, in, 32: instruction word; valid in the ack cycle.
- `pc4_id`, out, 32: IF/ID register, fetch address + 4.
- `instr_id`, out, 32: IF/ID register, instruction word (0 = bubble).
- `valid_id`, out, 1: IF/ID register holds a real instruction.

## Operation
- **Registers:** `pc`; state ∈ {IDLE, FETCH, HOLD}; a 32-bit skid buffer with its PC+4; `pend` flag with a 32-bit `pend_tgt`.
- **Request outputs:** `imem_req` = (state==FETCH). `imem_addr` = `pc`. `pc` never changes while `imem_req`=1 and `imem_ack`=0.
- **Redirect qualifier:** `redir` = `valid_id & ~stall & (pc_select != 0)`. The target is selected by `pc_select`. `pc_select` and the targets are ignored otherwise.
- **Next PC on a completing fetch:** `redir` ? target : `pend` ? `pend_tgt` : `pc`+4. `pend` is cleared.
- **IDLE:** entered on reset. Go to FETCH on the next edge.
- **FETCH, ack & ~stall:** IF/ID ← {`pc`+4, `imem_data`, valid=1}. `pc` ← next PC. Stay in FETCH.
- **FETCH, ack & stall:** IF/ID holds. Skid buffer ← {`pc`+4, `imem_data`}. `pc` ← next PC. Go to HOLD.
- **FETCH, ~ack & ~stall:** IF/ID ← bubble {0, 0, valid=0}. If `redir`: `pend` ← 1, `pend_tgt` ← target; the in-flight word is the delay slot.
- **FETCH, ~ack & stall:** no change.
- **HOLD:** `imem_req`=0.
  - stall=1: hold.
  - stall=0: IF/ID ← skid buffer (valid=1). If `redir`, `pc` ← target, since the buffered word is the delay slot. Go to FETCH.
- **Delay slot:** the word at branch+4 always executes. No instruction is ever squashed.
- `pend` and `redir` never coincide: while `pend`=1, `valid_id`=0.
- **Arithmetic:** PC+4 wraps modulo 2^32. Targets are taken verbatim; no alignment check.

## Timing
- **Reset values (asynchronous, `reset_0`=0):**
  - state=IDLE, `pc`=`RESET_PC`, `pend`=0, `pend_tgt`=0, skid buffer=0.
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `pc4_id`=0, `instr_id`=0, `valid_id`=0.
- **Reset mid-fetch:** the request is abandoned and a late `imem_ack` is ignored. The first request after release is `RESET_PC`.
- **Fetch latency:** `imem_req` rises one cycle after reset release. With zero-wait memory (ack in the request cycle), the word appears on `instr_id` after the next edge, 2 edges after release.
- **Throughput:** one instruction per cycle when ack is held high and stall is low.
- **Wait states:** each wait cycle inserts one bubble into ID.
- **Registered outputs:** `imem_req` and `imem_addr` come from state and `pc` only, with no combinational path from memory inputs. `pc_select` and `stall` reach only D-inputs.

## Test plan
1. **Reset and sequential fetch.**
   - Stimulus: `RESET_PC`=0x0000_0040, ack tied 1, stall 0, `pc_select` 00.
   - Required response: `imem_addr` = 0x40, 0x44, 0x48…; `instr_id` follows one cycle later with `pc4_id` = 0x44, 0x48…; `valid_id` = 1 from the second edge after release.
2. **Taken branch with delay slot.**
   - Stimulus: `instr_id`=beq @0x100; `pc_select` 01, `pc_b`=0x200 that cycle; zero-wait memory.
   - Required response: next `instr_id` is word @0x104; the following is word @0x200. No bubble.
3. **Wait states plus redirect.**
   - Stimulus: ack delayed 3 cycles; jr @0x100 in ID with `pc_r`=0x300 while the fetch of 0x104 waits.
   - Required response: `pend`=1; 0x104 delivered after ack; next `imem_addr`=0x300; bubbles (`valid_id`=0, `instr_id`=0) during the waits.
4. **Stall during ack.**
   - Stimulus: stall=1 for 2 cycles coinciding with ack of 0x108.
   - Required response: `instr_id` frozen; `imem_req`=0 in HOLD; after stall drops, word @0x108 is delivered and the fetch resumes at 0x10C. Nothing is lost or duplicated.
5. **Stall release with redirect from HOLD.**
   - Stimulus: HOLD with the buffered delay slot @0x0FFC; stall drops while j @0x0FF8 in ID gives `pc_j`=0x0000_0000.
   - Required response: buffered word delivered, then `imem_addr`=0x0.
   - Also check: PC 0xFFFF_FFFC sequential wrap gives `pc4_id`=0.
6. **Asynchronous reset mid-operation.**
   - Stimulus: assert `reset_0` between edges during a wait state.
   - Required response: all outputs reach their reset values immediately; a later ack is ignored; refetch starts at `RESET_PC`.
